// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer for the EX stage.
// Shifts up to STEP bits per cycle and stalls the pipeline until the result is ready.
module shift_seq_ctrl #(
    parameter int STEP = 4,
    parameter int DW   = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          flush,
    input  logic [1:0]    op,
    input  logic          ShiftSrcE,
    input  logic [DW-1:0] SrcAE,
    input  logic [DW-1:0] SrcBE,
    input  logic [DW-1:0] SignImmE,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [DW-1:0] operand;
    logic [1:0]    opReg;
    logic [4:0]    rem;
    logic [4:0]    amtSel;
    logic [4:0]    k;
    logic [4:0]    remNext;
    logic [DW-1:0] shifted;
    logic          accept;
    logic          unusedBits;

    assign amtSel = ShiftSrcE ? SignImmE[10:6] : SrcAE[4:0];
    assign unusedBits = ^{SrcAE[DW-1:5], SignImmE[DW-1:11], SignImmE[5:0]};

    // starts arriving while SHIFT is busy are ignored; EX is frozen by stall
    assign accept = start && !flush && (state != SHIFT);
    assign done   = (state == DONE);
    assign stall  = !flush && ((state == SHIFT) || (start && state != SHIFT));

    always_comb begin
        k       = (int'(rem) > STEP) ? 5'(STEP) : rem;
        remNext = rem - k;
        shifted = operand >> k;
        unique case (1'b1)
            (opReg == 2'b00): shifted = operand << k;
            (opReg == 2'b10): shifted = DW'($signed(operand) >>> k);
            default:          shifted = operand >> k;
        endcase
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stateNext = (amtSel == 5'd0) ? DONE : SHIFT;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                SHIFT: stateNext = (remNext == 5'd0) ? DONE : SHIFT;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // result only moves on entry to DONE, so it holds through IDLE and flushes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            operand <= '0;
            opReg   <= 2'b00;
            rem     <= 5'd0;
            result  <= '0;
        end else if (!flush) begin
            if (accept) begin
                operand <= SrcBE;
                opReg   <= op;
                rem     <= amtSel;
                if (amtSel == 5'd0) begin
                    result <= SrcBE;
                end
            end else if (state == SHIFT) begin
                operand <= shifted;
                rem     <= remNext;
                if (remNext == 5'd0) begin
                    result <= shifted;
                end
            end
        end
    end

endmodule
